// File: rtl/if_defs.sv
// Shared fetch-unit definitions: FSM states, reset PC and the NMOS 6502 length decode.
package if_defs;

  typedef enum logic [2:0] {
    OP_REQ,
    OP_WAIT,
    LO_WAIT,
    HI_WAIT,
    PRESENT,
    HALT
  } if_state_e;

  localparam logic [15:0] IfResetPc = 16'h0100;

  // Decoded on the aaa/bbb/cc fields of the opcode; anything outside the documented set is illegal.
  function automatic logic op_is_illegal(input logic [7:0] op);
    logic [2:0] a;
    logic [2:0] b;
    logic       ill;
    a   = op[7:5];
    b   = op[4:2];
    ill = 1'b0;
    case (op[1:0])
      2'b01: ill = (op == 8'h89);
      2'b10: begin
        case (b)
          3'd0:    ill = (a != 3'd5);
          3'd4:    ill = 1'b1;
          3'd6:    ill = !(a inside {3'd4, 3'd5});
          3'd7:    ill = (a == 3'd4);
          default: ill = 1'b0;
        endcase
      end
      2'b00: begin
        case (b)
          3'd0:    ill = (a == 3'd4);
          3'd1:    ill = a inside {3'd0, 3'd2, 3'd3};
          3'd3:    ill = (a == 3'd0);
          3'd5:    ill = !(a inside {3'd4, 3'd5});
          3'd7:    ill = (a != 3'd5);
          default: ill = 1'b0;
        endcase
      end
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Illegal opcodes report length 1 so they can be presented as single-byte instructions.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] len;
    a   = op[7:5];
    b   = op[4:2];
    len = 2'd1;
    if (!op_is_illegal(op)) begin
      case (op[1:0])
        2'b01: len = (b inside {3'd3, 3'd6, 3'd7}) ? 2'd3 : 2'd2;
        2'b10: begin
          case (b)
            3'd0, 3'd1, 3'd5: len = 2'd2;
            3'd2, 3'd6:       len = 2'd1;
            default:          len = 2'd3;
          endcase
        end
        default: begin
          case (b)
            3'd0:       len = (op == 8'h20) ? 2'd3 : ((a >= 3'd5) ? 2'd2 : 2'd1);
            3'd2, 3'd6: len = 2'd1;
            3'd3, 3'd7: len = 2'd3;
            default:    len = 2'd2;
          endcase
        end
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/if_len_decode.sv
// Combinational opcode length / legality decoder.
module if_len_decode
  import if_defs::*;
(
  input  logic [7:0] i_opcode,
  output logic [1:0] o_len,
  output logic       o_illegal
);

  assign o_len     = op_len(i_opcode);
  assign o_illegal = op_is_illegal(i_opcode);

endmodule

// File: rtl/if_fetch_unit.sv
// Byte-serial 6502 instruction fetch: reads opcode and operands, presents them with a handshake.
// Define IF_ILLEGAL_TRAP_EN to halt fetch on undocumented opcodes instead of presenting them.
module if_fetch_unit
  import if_defs::*;
#(
  parameter logic [15:0] RESET_PC = IfResetPc
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_op_lo,
  output logic [7:0]  instr_op_hi,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        if_halt
);

  if_state_e   r_state, w_state_d;
  logic [15:0] r_pc, w_pc_d;
  logic [7:0]  r_opcode, w_opcode_d;
  logic [7:0]  r_op_lo, w_op_lo_d;
  logic [7:0]  r_op_hi, w_op_hi_d;
  logic [1:0]  r_len, w_len_d;
  logic        r_rst_q;
  logic        w_rd_en;
  logic [15:0] w_rd_addr;
  logic [1:0]  w_dec_len;
  logic        w_dec_illegal;
  logic        w_trap;
  logic        w_quiet;

  if_len_decode u_len_decode (
    .i_opcode  (mem_rd_data),
    .o_len     (w_dec_len),
    .o_illegal (w_dec_illegal)
  );

`ifdef IF_ILLEGAL_TRAP_EN
  assign w_trap = w_dec_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = w_dec_illegal;
  assign w_trap           = 1'b0;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_pc_d     = r_pc;
    w_opcode_d = r_opcode;
    w_op_lo_d  = r_op_lo;
    w_op_hi_d  = r_op_hi;
    w_len_d    = r_len;
    w_rd_en    = 1'b0;
    w_rd_addr  = 16'h0000;
    case (r_state)
      // The cycle right after reset is held quiet so every output reads zero once.
      OP_REQ: begin
        if (!r_rst_q) begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_pc;
          w_state_d = OP_WAIT;
        end
      end
      OP_WAIT: begin
        w_opcode_d = mem_rd_data;
        w_op_lo_d  = 8'h00;
        w_op_hi_d  = 8'h00;
        w_len_d    = w_dec_len;
        if (w_trap) begin
          w_state_d = HALT;
        end else if (w_dec_len >= 2'd2) begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_pc + 16'd1;
          w_state_d = LO_WAIT;
        end else begin
          w_state_d = PRESENT;
        end
      end
      LO_WAIT: begin
        w_op_lo_d = mem_rd_data;
        if (r_len == 2'd3) begin
          w_rd_en   = 1'b1;
          w_rd_addr = r_pc + 16'd2;
          w_state_d = HI_WAIT;
        end else begin
          w_state_d = PRESENT;
        end
      end
      HI_WAIT: begin
        w_op_hi_d = mem_rd_data;
        w_state_d = PRESENT;
      end
      PRESENT: begin
        if (instr_ready) begin
          w_pc_d    = r_pc + {14'd0, r_len};
          w_state_d = OP_REQ;
        end
      end
      HALT: begin
        w_state_d = HALT;
      end
      default: begin
        w_state_d = OP_REQ;
      end
    endcase
    // A redirect overrides everything, including a coincident handshake; returning data is dropped.
    if (redirect_en) begin
      w_pc_d    = redirect_pc;
      w_state_d = OP_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= OP_REQ;
      r_pc     <= RESET_PC;
      r_opcode <= 8'h00;
      r_op_lo  <= 8'h00;
      r_op_hi  <= 8'h00;
      r_len    <= 2'd0;
      r_rst_q  <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_pc     <= w_pc_d;
      r_opcode <= w_opcode_d;
      r_op_lo  <= w_op_lo_d;
      r_op_hi  <= w_op_hi_d;
      r_len    <= w_len_d;
      r_rst_q  <= 1'b0;
    end
  end

  assign w_quiet      = rst | r_rst_q;
  assign mem_rd_en    = w_rd_en & ~w_quiet;
  assign mem_addr     = w_quiet ? 16'h0000 : w_rd_addr;
  assign instr_valid  = (r_state == PRESENT) & ~w_quiet;
  assign instr_opcode = w_quiet ? 8'h00 : r_opcode;
  assign instr_op_lo  = w_quiet ? 8'h00 : r_op_lo;
  assign instr_op_hi  = w_quiet ? 8'h00 : r_op_hi;
  assign instr_len    = w_quiet ? 2'd0 : r_len;
  assign instr_pc     = w_quiet ? 16'h0000 : r_pc;

`ifdef IF_ILLEGAL_TRAP_EN
  assign if_halt = (r_state == HALT) & ~w_quiet;
`else
  assign if_halt = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with a one-cycle-latency byte memory model.
module tb_if_fetch_unit;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  op;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [1:0]  len;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_op_lo;
  logic [7:0]  instr_op_hi;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        if_halt;

  logic [7:0]  mem [65536];
  int          n_checks = 0;
  int          n_errors = 0;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_data  (mem_rd_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_op_lo  (instr_op_lo),
    .instr_op_hi  (instr_op_hi),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .if_halt      (if_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data returns one cycle after the strobe; idle cycles return junk.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : 8'hEE;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {3'b0, instr_valid, mem_rd_en, if_halt, mem_addr, instr_opcode, instr_op_lo,
            instr_op_hi, instr_len, instr_pc};
  endfunction

  task automatic wait_req(input logic [15:0] pc, input bit at_req, output bit ok);
    int n = 0;
    if (!at_req) @(negedge clk);
    while (!(mem_rd_en === 1'b1 && mem_addr === pc) && n < 12) begin
      @(negedge clk);
      n++;
    end
    ok = (mem_rd_en === 1'b1 && mem_addr === pc);
    chk("req_addr", {mem_rd_en, mem_addr}, {1'b1, pc});
  endtask

  // Latency is counted in cycles from the opcode request to instr_valid.
  task automatic fetch_one(input logic [15:0] pc, input bit at_req, output int lat);
    bit ok;
    int n;
    lat = -1;
    wait_req(pc, at_req, ok);
    if (ok) begin
      n = 0;
      while (instr_valid !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      if (instr_valid === 1'b1) lat = n;
    end
  endtask

  task automatic check_instr(input string name, input vec_t v, input int lat);
    chk({name, "_fields"},
        {instr_valid, instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc},
        {1'b1, v.op, v.lo, v.hi, v.len, v.pc});
    chk({name, "_latency"}, lat, int'(v.len) + 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    @(posedge clk);
    #1 instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] pc);
    @(negedge clk);
    redirect_en = 1'b1;
    redirect_pc = pc;
    @(posedge clk);
    #1 redirect_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t listing [5];
    vec_t v;
    int   lat;
    bit   ok;

    listing[0] = '{16'h0100, 8'hA0, 8'h00, 8'h00, 2'd2};
    listing[1] = '{16'h0102, 8'h84, 8'h32, 8'h00, 2'd2};
    listing[2] = '{16'h0104, 8'hB1, 8'h1E, 8'h00, 2'd2};
    listing[3] = '{16'h0106, 8'hAA, 8'h00, 8'h00, 2'd1};
    listing[4] = '{16'h0107, 8'hC8, 8'h00, 8'h00, 2'd1};

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0100] = 8'hA0; mem[16'h0101] = 8'h00;
    mem[16'h0102] = 8'h84; mem[16'h0103] = 8'h32;
    mem[16'h0104] = 8'hB1; mem[16'h0105] = 8'h1E;
    mem[16'h0106] = 8'hAA; mem[16'h0107] = 8'hC8;
    mem[16'h010B] = 8'hC8;
    mem[16'h0121] = 8'hD0; mem[16'h0122] = 8'hE8;
    mem[16'hFFFF] = 8'h4C; mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h01;

    rst = 1'b1;
    instr_ready = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Listing at 0x0100 with instr_ready held high
    for (int i = 0; i < 5; i++) begin
      fetch_one(listing[i].pc, 1'b0, lat);
      check_instr($sformatf("listing%0d", i), listing[i], lat);
    end

    // Redirect to 0x0121, then redirect again while the D0 operand read is in flight
    redirect(16'h0121);
    wait_req(16'h0121, 1'b0, ok);
    @(negedge clk);
    chk("redir_op_wait_read", {mem_rd_en, mem_addr}, {1'b1, 16'h0122});
    redirect_en = 1'b1;
    redirect_pc = 16'h010B;
    @(posedge clk);
    #1 redirect_en = 1'b0;
    @(negedge clk);
    chk("redir_next_cycle", {instr_valid, mem_rd_en, mem_addr}, {1'b0, 1'b1, 16'h010B});
    fetch_one(16'h010B, 1'b1, lat);
    v = '{16'h010B, 8'hC8, 8'h00, 8'h00, 2'd1};
    check_instr("redir_target", v, lat);

    // Redirect coinciding with a handshake: target wins
    redirect_en = 1'b1;
    redirect_pc = 16'h0100;
    @(posedge clk);
    #1 redirect_en = 1'b0;
    fetch_one(16'h0100, 1'b0, lat);
    check_instr("redir_handshake", listing[0], lat);

    // Three-byte instruction straddling the top of memory
    redirect(16'hFFFF);
    fetch_one(16'hFFFF, 1'b0, lat);
    v = '{16'hFFFF, 8'h4C, 8'h00, 8'h01, 2'd3};
    check_instr("wrap_jmp", v, lat);
    fetch_one(16'h0002, 1'b0, lat);
    v = '{16'h0002, 8'hEA, 8'h00, 8'h00, 2'd1};
    check_instr("wrap_next", v, lat);

    // Back-pressure: hold B1 1E for five cycles
    instr_ready = 1'b0;
    do_reset();
    fetch_one(16'h0100, 1'b0, lat);
    accept();
    fetch_one(16'h0102, 1'b0, lat);
    check_instr("hold_pre", listing[1], lat);
    accept();
    fetch_one(16'h0104, 1'b0, lat);
    check_instr("hold_b1", listing[2], lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_cycle%0d", i),
          {instr_valid, mem_rd_en, instr_opcode, instr_op_lo, instr_op_hi, instr_len, instr_pc},
          {1'b1, 1'b0, 8'hB1, 8'h1E, 8'h00, 2'd2, 16'h0104});
    end
    accept();
    wait_req(16'h0106, 1'b0, ok);

    // Reset while in LO_WAIT of A0 00
    instr_ready = 1'b1;
    do_reset();
    wait_req(16'h0100, 1'b0, ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_lo_wait_outputs", all_outs(), 64'h0);
    @(negedge clk);
    chk("rst_lo_wait_refetch", {mem_rd_en, mem_addr}, {1'b1, 16'h0100});

    // Undocumented opcode 02 at the reset vector
    mem[16'h0100] = 8'h02;
    do_reset();
`ifdef IF_ILLEGAL_TRAP_EN
    repeat (6) @(negedge clk);
    chk("illegal_halt", {if_halt, mem_rd_en, instr_valid}, 3'b100);
    redirect(16'h0102);
    fetch_one(16'h0102, 1'b0, lat);
    check_instr("illegal_exit", listing[1], lat);
    chk("illegal_exit_halt", if_halt, 1'b0);
`else
    fetch_one(16'h0100, 1'b0, lat);
    v = '{16'h0100, 8'h02, 8'h00, 8'h00, 2'd1};
    check_instr("illegal_len1", v, lat);
    chk("illegal_no_halt", if_halt, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0100, the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_addr  output  16  byte address of the current memory read.
REQ-005 SHALL have port mem_rd_en  output  1  read strobe; read data returns exactly one cycle later.
REQ-006 SHALL have port mem_rd_data  input  8  read data, valid in the cycle after mem_rd_en.
REQ-007 SHALL have port instr_valid  output  1  assembled instruction available.
REQ-008 SHALL have port instr_ready  input  1  IE accepts the instruction.
REQ-009 SHALL have ports instr_opcode, instr_op_lo, instr_op_hi  output  8 each  opcode and operand bytes.
REQ-010 SHALL have port instr_len  output  2  instruction length in bytes (1..3).
REQ-011 SHALL have port instr_pc  output  16  address of the opcode byte.
REQ-012 SHALL have ports redirect_en  input  1, and redirect_pc  input  16  branch/JMP target from IE.
REQ-013 SHALL have port if_halt  output  1  fetch stopped on an illegal opcode.

Function
REQ-014 SHALL implement the states OP_REQ, OP_WAIT, LO_WAIT, HI_WAIT, PRESENT and HALT.
REQ-015 OP_REQ SHALL assert mem_rd_en with mem_addr=pc, then go to OP_WAIT.
REQ-016 OP_WAIT SHALL capture the opcode and decode its length; if len>=2 it SHALL read pc+1 and go to LO_WAIT, otherwise go to PRESENT.
REQ-017 LO_WAIT SHALL capture op_lo; if len==3 it SHALL read pc+2 and go to HI_WAIT, otherwise go to PRESENT.
REQ-018 HI_WAIT SHALL capture op_hi, then go to PRESENT.
REQ-019 PRESENT SHALL hold instr_valid=1 and all instr_* outputs stable until instr_ready=1.
REQ-020 On instr_valid&&instr_ready, pc SHALL become pc+instr_len and the state SHALL go to OP_REQ.
REQ-021 instr_valid SHALL rise 2, 3 or 4 cycles after OP_REQ for lengths 1, 2 and 3 respectively.
REQ-022 Operand bytes not fetched SHALL read as 8'h00.
REQ-023 The length decode SHALL follow the documented NMOS 6502 table:
- 1 byte: implied and accumulator modes, plus BRK, RTI and RTS.
- 2 bytes: immediate, zp, zp,X, zp,Y, (zp,X), (zp),Y and relative modes (BCC..BVS).
- 3 bytes: abs, abs,X, abs,Y, indirect, JMP and JSR.
REQ-024 All PC and address arithmetic SHALL be 16-bit modulo; a read after 16'hFFFF SHALL wrap to 16'h0000.
REQ-025 redirect_en SHALL win in every state:
- next cycle: pc=redirect_pc, state=OP_REQ, instr_valid=0;
- in-flight read data SHALL be discarded.
REQ-026 When redirect_en coincides with a PRESENT handshake, the instruction SHALL count as accepted and the redirect target SHALL be used.
REQ-027 mem_rd_en SHALL be 0 in PRESENT and HALT.

Reset
REQ-028 On rst the block SHALL set pc=RESET_PC and state=OP_REQ.
REQ-029 On rst all outputs SHALL be 0: instr_valid, mem_rd_en, if_halt, and the instr_* and mem_addr buses.
REQ-030 rst SHALL override redirect_en and any pending handshake, in any state including mid-fetch.

Configuration
REQ-031 With IF_ILLEGAL_TRAP_EN defined, an undocumented opcode seen in OP_WAIT SHALL go to HALT with if_halt=1 and no instruction presented; exit SHALL be only via rst or redirect_en.
REQ-032 Without IF_ILLEGAL_TRAP_EN, an undocumented opcode SHALL be presented as a length-1 instruction and if_halt SHALL be tied 0.

Structure
REQ-033 The shared package if_defs SHALL hold the state enum, the RESET_PC default, the length function and the illegal-opcode predicate.
REQ-034 The length decode SHALL be a combinational sub-module if_len_decode (opcode in; len and illegal out).

Verification
REQ-035 Load the IF listing at 0x0100 with instr_ready=1 -> (A0,00,len2,pc0100), (84,32,len2,0102), (B1,1E,len2,0104), (AA,len1,0106), (C8,len1,0107).
REQ-036 Hold instr_ready=0 for 5 cycles on B1 1E -> outputs stable, mem_rd_en=0, then the next fetch is at 0x0106.
REQ-037 Pulse redirect_en with 0x010B while at 0x0121 (D0 E8) -> next instruction (C8,len1,pc010B); stale read data is ignored.
REQ-038 Place 4C at 0xFFFF and 00 01 at 0x0000/0x0001 -> (4C,00,01,len3,pcFFFF); next pc is 0x0002.
REQ-039 Opcode 02 at 0x0100 -> with the macro, if_halt=1 and mem_rd_en stays 0; without it, (02,len1) is presented.
REQ-040 Assert rst in LO_WAIT -> next cycle all outputs are 0 and the following read is at 0x0100.
